// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage with bus handshake, one-entry skid buffer and redirect/drop handling.
// Optional macro IF_NOP_BUBBLE_EN selects addi x0,x0,0 as the bubble word (default 32'h0).
`default_nettype none

`ifndef HOLDBUS
`define HOLDBUS 2:0
`endif
`ifndef Hold_None
`define Hold_None 3'b000
`endif

module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [`HOLDBUS]   hold_flag,
  input  logic              jump_flag,
  input  logic [31:0]       jump_addr,
  input  logic              int_flag,
  input  logic [31:0]       int_addr,
  output logic              ibus_req,
  output logic [31:0]       ibus_addr,
  input  logic              ibus_rdy,
  input  logic [31:0]       ibus_rdata,
  output logic [31:0]       IF_inst_data,
  output logic [31:0]       IF_inst_addr,
  output logic              IF_inst_valid
);

`ifdef IF_NOP_BUBBLE_EN
  localparam logic [31:0] C_BUBBLE = 32'h0000_0013;
`else
  localparam logic [31:0] C_BUBBLE = 32'h0000_0000;
`endif

  typedef enum logic [0:0] {
    S_REQ  = 1'b0,
    S_DROP = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_req_addr;
  logic [31:0] r_out_data;
  logic [31:0] r_out_addr;
  logic        r_out_valid;
  logic [31:0] r_buf_data;
  logic [31:0] r_buf_addr;
  logic        r_buf_valid;
  logic [31:0] r_target;

  logic        w_req;
  logic        w_done;
  logic        w_stall;
  logic        w_redir;
  logic [31:0] w_target;

  // A full skid buffer blocks new fetches; a dropped request must still be completed.
  assign w_req    = (r_state == S_DROP) ? 1'b1 : ~r_buf_valid;
  assign w_done   = w_req & ibus_rdy;
  assign w_stall  = (hold_flag != `Hold_None);
  assign w_redir  = int_flag | jump_flag;
  assign w_target = int_flag ? int_addr : jump_addr;

  assign ibus_req      = w_req;
  assign ibus_addr     = r_req_addr;
  assign IF_inst_data  = r_out_data;
  assign IF_inst_addr  = r_out_addr;
  assign IF_inst_valid = r_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_REQ;
      r_req_addr  <= RESET_PC;
      r_out_data  <= C_BUBBLE;
      r_out_addr  <= 32'h0;
      r_out_valid <= 1'b0;
      r_buf_data  <= 32'h0;
      r_buf_addr  <= 32'h0;
      r_buf_valid <= 1'b0;
      r_target    <= 32'h0;
    end else if (w_redir) begin
      // Redirect overrides hold; any data completing now is stale.
      r_out_data  <= C_BUBBLE;
      r_out_valid <= 1'b0;
      r_buf_valid <= 1'b0;
      if (w_req && !w_done) begin
        r_target <= w_target;
        r_state  <= S_DROP;
      end else begin
        r_req_addr <= w_target;
        r_state    <= S_REQ;
      end
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_done) begin
            r_req_addr <= r_req_addr + 32'd4;
          end
          if (!w_stall) begin
            if (r_buf_valid) begin
              r_out_data  <= r_buf_data;
              r_out_addr  <= r_buf_addr;
              r_out_valid <= 1'b1;
              r_buf_valid <= 1'b0;
            end else if (w_done) begin
              r_out_data  <= ibus_rdata;
              r_out_addr  <= r_req_addr;
              r_out_valid <= 1'b1;
            end else begin
              r_out_data  <= C_BUBBLE;
              r_out_valid <= 1'b0;
            end
          end else if (w_done) begin
            r_buf_data  <= ibus_rdata;
            r_buf_addr  <= r_req_addr;
            r_buf_valid <= 1'b1;
          end
        end
        S_DROP: begin
          if (w_done) begin
            r_req_addr <= r_target;
            r_state    <= S_REQ;
          end
          if (!w_stall) begin
            r_out_data  <= C_BUBBLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed plus randomized check of if_fetch against a fetch-stream model.
`default_nettype none

module tb_if_fetch;

  localparam logic [31:0] K = 32'hA5A5_A5A5;
`ifdef IF_NOP_BUBBLE_EN
  localparam logic [31:0] BUB = 32'h0000_0013;
`else
  localparam logic [31:0] BUB = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  hold_flag = 3'd0;
  logic        jump_flag = 1'b0;
  logic [31:0] jump_addr = 32'h0;
  logic        int_flag = 1'b0;
  logic [31:0] int_addr = 32'h0;
  logic        ibus_rdy = 1'b1;
  logic [31:0] ibus_rdata;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic [31:0] IF_inst_data;
  logic [31:0] IF_inst_addr;
  logic        IF_inst_valid;

  logic        u2_req;
  logic [31:0] u2_addr;
  logic [31:0] u2_data;
  logic [31:0] u2_iaddr;
  logic        u2_valid;

  always #5 clk = ~clk;

  assign ibus_rdata = ibus_addr ^ K;

  if_fetch u_dut (
    .clk(clk), .rst_n(rst_n), .hold_flag(hold_flag),
    .jump_flag(jump_flag), .jump_addr(jump_addr),
    .int_flag(int_flag), .int_addr(int_addr),
    .ibus_req(ibus_req), .ibus_addr(ibus_addr),
    .ibus_rdy(ibus_rdy), .ibus_rdata(ibus_rdata),
    .IF_inst_data(IF_inst_data), .IF_inst_addr(IF_inst_addr),
    .IF_inst_valid(IF_inst_valid)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .hold_flag(hold_flag),
    .jump_flag(jump_flag), .jump_addr(jump_addr),
    .int_flag(int_flag), .int_addr(int_addr),
    .ibus_req(u2_req), .ibus_addr(u2_addr),
    .ibus_rdy(ibus_rdy), .ibus_rdata(ibus_rdata),
    .IF_inst_data(u2_data), .IF_inst_addr(u2_iaddr),
    .IF_inst_valid(u2_valid)
  );

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a fetch pointer, a pending redirect target while draining a stale
  // request, a queue of captured-but-unissued instructions, and the IF/ID word.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } fe_t;

  logic [31:0] m_pc;
  bit          m_drop;
  logic [31:0] m_tgt;
  fe_t         m_skid[$];
  bit          m_ov;
  logic [31:0] m_oa;
  logic [31:0] m_od;

  function automatic bit m_req();
    return m_drop || (m_skid.size() == 0);
  endfunction

  task automatic model_reset();
    m_pc   = 32'h0;
    m_drop = 1'b0;
    m_tgt  = 32'h0;
    m_skid.delete();
    m_ov   = 1'b0;
    m_oa   = 32'h0;
    m_od   = BUB;
  endtask

  task automatic model_update();
    bit req, done, stall;
    logic [31:0] tgt;
    fe_t f;
    req   = m_req();
    done  = req && ibus_rdy;
    stall = (hold_flag != 3'd0);
    tgt   = int_flag ? int_addr : jump_addr;
    f.a   = m_pc;
    f.d   = m_pc ^ K;
    if (int_flag || jump_flag) begin
      m_ov = 1'b0;
      m_od = BUB;
      m_skid.delete();
      if (req && !done) begin
        m_drop = 1'b1;
        m_tgt  = tgt;
      end else begin
        m_drop = 1'b0;
        m_pc   = tgt;
      end
    end else if (m_drop) begin
      if (done) begin
        m_pc   = m_tgt;
        m_drop = 1'b0;
      end
      if (!stall) begin
        m_ov = 1'b0;
        m_od = BUB;
      end
    end else begin
      if (!stall) begin
        if (m_skid.size() != 0) begin
          f = m_skid.pop_front();
          m_ov = 1'b1; m_oa = f.a; m_od = f.d;
        end else if (done) begin
          m_ov = 1'b1; m_oa = f.a; m_od = f.d;
        end else begin
          m_ov = 1'b0; m_od = BUB;
        end
      end else if (done) begin
        m_skid.push_back(f);
      end
      if (done) m_pc = m_pc + 32'd4;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("ibus_req", {31'h0, ibus_req}, {31'h0, m_req()});
      chk("ibus_addr", ibus_addr, m_pc);
      chk("if_valid", {31'h0, IF_inst_valid}, {31'h0, m_ov});
      chk("if_data", IF_inst_data, m_od);
      if (m_ov) chk("if_addr", IF_inst_addr, m_oa);
    end
  end

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_valid"}, {31'h0, IF_inst_valid}, 32'h0);
    chk({nm, "_iaddr"}, IF_inst_addr, 32'h0);
    chk({nm, "_data"}, IF_inst_data, BUB);
    chk({nm, "_addr"}, ibus_addr, 32'h0);
    chk({nm, "_u2valid"}, {31'h0, u2_valid}, 32'h0);
    chk({nm, "_u2iaddr"}, u2_iaddr, 32'h0);
    chk({nm, "_u2data"}, u2_data, BUB);
    chk({nm, "_u2addr"}, u2_addr, 32'hFFFF_FFF8);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;
    chk("rel_req", {31'h0, ibus_req}, 32'h1);
    chk("rel_u2req", {31'h0, u2_req}, 32'h1);
    chk("seq_a0", ibus_addr, 32'h0);
    step();
    chk("seq_a4", ibus_addr, 32'h4);
    chk("u2_a1", u2_addr, 32'hFFFF_FFFC);
    chk("seq_o0", IF_inst_addr, 32'h0);
    chk("seq_d0", IF_inst_data, 32'h0 ^ K);
    chk("seq_v0", {31'h0, IF_inst_valid}, 32'h1);
    step();
    chk("seq_a8", ibus_addr, 32'h8);
    chk("u2_wrap", u2_addr, 32'h0);
    chk("seq_o4", IF_inst_addr, 32'h4);

    hold_flag = 3'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_o4", IF_inst_addr, 32'h4);
      chk("hold_req0", {31'h0, ibus_req}, 32'h0);
    end
    hold_flag = 3'd0;
    step();
    chk("skid_o8", IF_inst_addr, 32'h8);
    chk("skid_d8", IF_inst_data, 32'h8 ^ K);
    chk("skid_a12", ibus_addr, 32'hC);
    step();
    chk("skid_o12", IF_inst_addr, 32'hC);
    step();

    ibus_rdy = 1'b0; jump_flag = 1'b1; jump_addr = 32'h100;
    step();
    jump_flag = 1'b0;
    chk("drop_a20", ibus_addr, 32'h14);
    chk("drop_v0", {31'h0, IF_inst_valid}, 32'h0);
    step();
    chk("drop_hold20", ibus_addr, 32'h14);
    ibus_rdy = 1'b1;
    step();
    chk("drop_a100", ibus_addr, 32'h100);
    chk("drop_v0b", {31'h0, IF_inst_valid}, 32'h0);
    step();
    chk("jmp_o100", IF_inst_addr, 32'h100);
    chk("jmp_d100", IF_inst_data, 32'h100 ^ K);

    int_flag = 1'b1; int_addr = 32'h80; jump_flag = 1'b1; jump_addr = 32'h200;
    step();
    int_flag = 1'b0; jump_flag = 1'b0;
    chk("int_a80", ibus_addr, 32'h80);
    chk("int_v0", {31'h0, IF_inst_valid}, 32'h0);
    chk("int_bub", IF_inst_data, BUB);
    step();
    chk("int_o80", IF_inst_addr, 32'h80);

    ibus_rdy = 1'b0;
    chk("mid_req", {31'h0, ibus_req}, 32'h1);
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk_reset_vals("mid");
    @(negedge clk);
    #1 rst_n = 1'b1;
    ibus_rdy = 1'b1;
    chk("mid_rel_req", {31'h0, ibus_req}, 32'h1);
    chk("mid_rel_a", ibus_addr, 32'h0);
    step();
    chk("mid_o0", IF_inst_addr, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      hold_flag = ($urandom_range(0, 9) < 3) ? 3'($urandom_range(1, 7)) : 3'd0;
      ibus_rdy  = ($urandom_range(0, 9) < 6);
      jump_flag = ($urandom_range(0, 15) == 0);
      int_flag  = ($urandom_range(0, 39) == 0);
      jump_addr = $urandom & 32'hFFFF_FFFC;
      int_addr  = $urandom & 32'hFFFF_FFFC;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
